axi_txn_arbiter: RTL
====================

// Module: axi_txn_arbiter
// PURPOSE
//  Shares the single burst Master between N_REQ requesters. Accepts burst read/write
//  commands, grants one at a time round-robin, and pulses the Master's en/en_ start strobes.
//  Drives tb_R/tb_W/INDATA and watches the R and B channel handshakes to detect completion.
//  Returns per-requester done/status. Sits between client logic and Master.
// PARAMETERS
//  N_REQ    2    number of requesters (2..4)
//  CMD_W    16   command width: [15:8] addr, [7:4] burst len (beats), [3:0] ID
//  DATA_W   128  write payload width (8-bit beats, beat k = [8k+7:8k])
//  TMO      255  cycles allowed per transaction before timeout
// PORTS
//  clk        in   1              system clock, rising edge
//  rst        in   1              asynchronous reset, active-low
//  req_valid  in   N_REQ          per-requester command valid
//  req_ready  out  N_REQ          per-requester command accepted (1-cycle pulse)
//  req_write  in   N_REQ          1 = burst write, 0 = burst read
//  req_cmd    in   N_REQ*CMD_W    packed commands, requester i at [i*CMD_W +: CMD_W]
//  req_data   in   N_REQ*DATA_W   packed write payloads
//  en         out  1              read start strobe to Master
//  en_        out  1              write start strobe to Master
//  tb_R       out  CMD_W          read command to Master
//  tb_W       out  CMD_W          write command to Master
//  INDATA     out  DATA_W         write payload to Master
//  RVALID, RREADY, RLAST  in 1    read-channel monitor (from Slave/Master)
//  BVALID, BREADY         in 1    write-response monitor
//  BRESP      in   5              write response code
//  done       out  N_REQ          1-cycle completion pulse, one-hot, to owning requester
//  status     out  2              valid with done: 00 OK, 01 slave err, 10 timeout, 11 len err
//  busy       out  1              a transaction is outstanding
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE. All outputs 0. RR pointer = 0. Beat/timeout counters 0.
//  FSM: IDLE -> ISSUE -> WAIT_R | WAIT_B -> DONE -> IDLE.
//  IDLE: pick the first valid requester from rr_ptr upward (wrap mod N_REQ).
//   Pulse req_ready[g] for 1 cycle. Latch cmd, write bit, payload. Go to ISSUE next cycle.
//  Len field 0: no issue to Master. Go straight to DONE with status 11.
//  ISSUE (1 cycle): en=1 (read) or en_=1 (write).
//   Write: tb_W=cmd and INDATA=payload. Read: tb_R=cmd.
//   The unused command bus stays 0. tb_*/INDATA are held stable until DONE.
//  WAIT_R: on each cycle with RVALID&RREADY, beat_cnt++.
//   On a beat with RLAST, leave WAIT_R for DONE.
//   status 00 if beat_cnt+1==len, else 11.
//  WAIT_B: on BVALID&BREADY, go to DONE.
//   status 00 if BRESP==0, else 01.
//  Timeout: counter starts at ISSUE. When it reaches TMO in WAIT_*, go to DONE with status 10.
//   A handshake arriving in the same cycle as the timeout wins (status 00/01/11).
//  DONE (1 cycle): done[g]=1 with status.
//   Clear tb_R/tb_W/INDATA. rr_ptr=(g+1) mod N_REQ. Next state IDLE.
//   Earliest next grant is the cycle after DONE.
//  busy=1 in ISSUE, WAIT_R, WAIT_B and DONE.
//  Requests in a non-IDLE state are ignored. req_ready stays 0.
//   A requester holds req_valid until it sees req_ready.
//  Reset mid-transaction: abort. No done pulse. Return to reset values.
//  Latency, IDLE with a valid request to the en/en_ strobe: 2 cycles (grant, issue).
// TESTING
//  1 Write req0 cmd=0x0131, data beats 01,02,03. BVALID&BREADY, BRESP=0 -> en_ pulse 1 cycle,
//    tb_W=0x0131, INDATA[23:0]=0x030201, then done[0], status 00.
//  2 Read req1 cmd=0x0131. 3 R beats, RLAST on the 3rd -> en pulse, tb_R=0x0131,
//    done[1], status 00. RLAST on the 2nd beat -> status 11.
//  3 req0 and req1 valid in the same cycle, back-to-back -> grant order 0,1,0,1.
//    No grant is issued while busy.
//  4 Write with BRESP=5'h02 -> status 01. No B handshake for TMO cycles -> status 10.
//  5 cmd len=0 -> no en/en_ pulse, done with status 11 two cycles after req_ready.
//  6 Assert rst in WAIT_R -> outputs 0 immediately, no done.
//    Next request is granted starting from req0.

Source files
------------

// File: rtl/axi_txn_arbiter.sv
// Round-robin arbiter sharing one burst Master between N_REQ requesters.
// Issues start strobes, monitors R/B handshakes, and reports per-requester done/status.
//
// state  | meaning
// IDLE   | waiting for a request; the cycle with req_ready high is still IDLE
// ISSUE  | en/en_ strobe visible, command/payload driven to Master
// WAIT_R | counting read beats until RLAST or timeout
// WAIT_B | waiting for write response or timeout
// DONE   | done/status pulse visible, buses cleared, pointer advanced
module axi_txn_arbiter #(
  parameter int N_REQ  = 2,
  parameter int CMD_W  = 16,
  parameter int DATA_W = 128,
  parameter int TMO    = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ-1:0]          req_write,
  input  logic [N_REQ*CMD_W-1:0]    req_cmd,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic                      en,
  output logic                      en_,
  output logic [CMD_W-1:0]          tb_R,
  output logic [CMD_W-1:0]          tb_W,
  output logic [DATA_W-1:0]         INDATA,
  input  logic                      RVALID,
  input  logic                      RREADY,
  input  logic                      RLAST,
  input  logic                      BVALID,
  input  logic                      BREADY,
  input  logic [4:0]                BRESP,
  output logic [N_REQ-1:0]          done,
  output logic [1:0]                status,
  output logic                      busy
);

  localparam int PTR_W = (N_REQ > 2) ? 2 : 1;
  localparam int TMO_W = $clog2(TMO + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_R, WAIT_B, DONE} state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   gnt_idx;
  logic [CMD_W-1:0]   cmd_q;
  logic               write_q;
  logic [DATA_W-1:0]  data_q;
  logic [3:0]         beat_cnt;
  logic [TMO_W-1:0]   tmo_cnt;

  logic               pick_vld;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   sel;
  logic [N_REQ-1:0]   pick_oh;
  logic [N_REQ-1:0]   gnt_oh;
  logic [PTR_W-1:0]   rr_next;
  logic               r_hs;
  logic               b_hs;
  logic               fin;
  logic [1:0]         fin_st;

  assign pick_oh = N_REQ'(1) << pick_idx;
  assign gnt_oh  = N_REQ'(1) << gnt_idx;
  assign rr_next = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign r_hs    = RVALID & RREADY;
  assign b_hs    = BVALID & BREADY;

  // Scan downward so the requester closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    sel      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sel = PTR_W'((int'(rr_ptr) + k) % N_REQ);
      if (req_valid[sel]) begin
        pick_vld = 1'b1;
        pick_idx = sel;
      end
    end
  end

  // A handshake in the timeout cycle takes priority over the timeout.
  always_comb begin
    fin    = 1'b0;
    fin_st = 2'b00;
    if (state == WAIT_R) begin
      if (r_hs && RLAST) begin
        fin    = 1'b1;
        fin_st = ((5'(beat_cnt) + 5'd1) == 5'(cmd_q[7:4])) ? 2'b00 : 2'b11;
      end else if (!r_hs && tmo_cnt == TMO_W'(TMO)) begin
        fin    = 1'b1;
        fin_st = 2'b10;
      end
    end else if (state == WAIT_B) begin
      if (b_hs) begin
        fin    = 1'b1;
        fin_st = (BRESP == 5'd0) ? 2'b00 : 2'b01;
      end else if (tmo_cnt == TMO_W'(TMO)) begin
        fin    = 1'b1;
        fin_st = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_idx   <= '0;
      cmd_q     <= '0;
      write_q   <= 1'b0;
      data_q    <= '0;
      beat_cnt  <= '0;
      tmo_cnt   <= '0;
      req_ready <= '0;
      en        <= 1'b0;
      en_       <= 1'b0;
      tb_R      <= '0;
      tb_W      <= '0;
      INDATA    <= '0;
      done      <= '0;
      status    <= 2'b00;
      busy      <= 1'b0;
    end else begin
      req_ready <= '0;
      en        <= 1'b0;
      en_       <= 1'b0;
      done      <= '0;
      status    <= 2'b00;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (|req_ready) begin
            state    <= ISSUE;
            busy     <= 1'b1;
            tmo_cnt  <= '0;
            beat_cnt <= '0;
            if (cmd_q[7:4] != 4'd0) begin
              if (write_q) begin
                en_    <= 1'b1;
                tb_W   <= cmd_q;
                INDATA <= data_q;
              end else begin
                en   <= 1'b1;
                tb_R <= cmd_q;
              end
            end
          end else if (pick_vld) begin
            req_ready <= pick_oh;
            gnt_idx   <= pick_idx;
            cmd_q     <= req_cmd[int'(pick_idx)*CMD_W +: CMD_W];
            write_q   <= req_write[pick_idx];
            data_q    <= req_data[int'(pick_idx)*DATA_W +: DATA_W];
          end
        end
        ISSUE: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (cmd_q[7:4] == 4'd0) begin
            state  <= DONE;
            done   <= gnt_oh;
            status <= 2'b11;
          end else begin
            state <= write_q ? WAIT_B : WAIT_R;
          end
        end
        WAIT_R, WAIT_B: begin
          if (fin) begin
            state  <= DONE;
            done   <= gnt_oh;
            status <= fin_st;
            tb_R   <= '0;
            tb_W   <= '0;
            INDATA <= '0;
          end else begin
            // Saturate so a non-final beat in the timeout cycle only defers the timeout.
            if (tmo_cnt != TMO_W'(TMO)) tmo_cnt <= tmo_cnt + 1'b1;
            if (state == WAIT_R && r_hs) beat_cnt <= beat_cnt + 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy   <= 1'b0;
          rr_ptr <= rr_next;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
